alu_result_hist: RTL and testbench
==================================

// Module: alu_result_hist
// PURPOSE
// Registered ALU result display stage with history. Captures each ALU result
// {overflow, data} into a DEPTH-entry circular history. The operator can scroll
// back through the history with Prev/Next. A per-cycle registered output drives
// the LED bank and shows either the data field or the overflow flag of the
// viewed entry. Sits between the ALU core and the board LEDs. It adds a sticky
// overflow indicator that the operator clears explicitly.
// PARAMETERS
// WIDTH  4  data bits of one result, excluding the overflow bit
// DEPTH  4  history entries; power of two, >= 2
// IDX_W  $clog2(DEPTH)  localparam; do not override
// PORTS
// Clk        in   1          rising-edge clock
// Rst        in   1          synchronous reset, active-low
// En         in   1          capture strobe; one capture per cycle while high
// FullIn     in   WIDTH+1    {overflow, data}; FullIn[WIDTH] = overflow
// sw         in   1          display select: 0 = data, 1 = overflow view
// Prev       in   1          level input; rising edge scrolls to an older entry
// Next       in   1          level input; rising edge scrolls to a newer entry
// ClrOvf     in   1          clear sticky overflow
// Out        out  WIDTH      registered LED output
// OvfSticky  out  1          set by any captured overflow; held until cleared
// ViewIdx    out  IDX_W      age of the viewed entry; 0 = newest
// Count      out  IDX_W+1    valid entries, saturates at DEPTH
// Empty      out  1          Count == 0 (combinational from registers)
// BEHAVIOUR
// - Reset: when Rst == 0 at a posedge, clear all entries, wr_ptr, Count,
//   ViewIdx, OvfSticky, Out and the Prev/Next edge registers to 0. Reset
//   overrides every other input in that cycle, including mid-scroll or
//   mid-capture.
// - Capture (En = 1): write FullIn to mem[wr_ptr]. Increment wr_ptr mod DEPTH.
//   Increment Count, saturating at DEPTH; when full, the oldest entry is
//   overwritten. Force ViewIdx to 0 (snap to newest).
// - Edge detect: prev_q and next_q register Prev and Next every cycle.
//   pe = Prev & ~prev_q; ne = Next & ~next_q.
// - Scroll, only when En = 0:
//   - pe & ~ne: ViewIdx++ if ViewIdx < Count-1, otherwise hold.
//   - ne & ~pe: ViewIdx-- if ViewIdx > 0, otherwise hold.
//   - pe & ne: no change.
//   - Count == 0: ViewIdx stays 0.
// - En and a scroll edge in the same cycle: capture wins and ViewIdx = 0. The
//   edge is consumed and is not replayed.
// - Viewed entry: mem[(wr_ptr - 1 - ViewIdx) mod DEPTH], using current
//   (pre-edge) register values.
// - Out is updated every cycle from the current state:
//   - Count == 0: Out <= 0.
//   - sw = 0: Out <= entry data.
//   - sw = 1: Out <= {WIDTH{entry overflow}}.
//   Latency: a capture at edge N appears on Out at edge N+1. A scroll edge or
//   sw change behaves the same way.
// - OvfSticky:
//   - Set when En & FullIn[WIDTH].
//   - Cleared by ClrOvf.
//   - Set wins if both happen in the same cycle.
// - The pointer wraps at DEPTH with no gap. ViewIdx never exceeds Count-1.
// TESTING
// - Reset: hold Rst=0 for 2 cycles with En=1 -> Out=0, Count=0, Empty=1,
//   OvfSticky=0.
// - Fill + wrap (WIDTH=4, DEPTH=4): capture 1,2,3,4,5 with no overflow ->
//   Count=4, Out=5; Prev x3 -> Out=4,3,2; a 4th Prev holds at 2.
// - Scroll vs capture: at ViewIdx=2, pulse Prev in the same cycle as En with
//   FullIn=0x0A -> ViewIdx=0, next-cycle Out=0xA.
// - Overflow view:
//   - Capture FullIn=5'b1_0011 -> OvfSticky=1; with sw=1, Out=4'hF.
//   - Capture 5'b0_0001 -> with sw=1, Out=0 and OvfSticky stays 1.
// - Sticky clear: ClrOvf=1 in the same cycle as capturing 5'b1_0000 ->
//   OvfSticky=1. ClrOvf=1 alone on the next cycle -> OvfSticky=0.
// - Edge rules: hold Prev high for 5 cycles -> ViewIdx moves once. Pulse Prev
//   and Next in the same cycle -> no change. Pulse Next at ViewIdx=0 ->
//   ViewIdx stays 0.

Source files
------------

// File: rtl/alu_result_hist_if.sv
// Bus between the ALU core / board controls and the result history display.
// The master side drives the capture and operator controls; the slave side
// returns the LED value and the history status.
interface alu_result_hist_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
);
   localparam int IDX_W = $clog2(DEPTH);

   logic             En;
   logic [WIDTH:0]   FullIn;
   logic             sw;
   logic             Prev;
   logic             Next;
   logic             ClrOvf;
   logic [WIDTH-1:0] Out;
   logic             OvfSticky;
   logic [IDX_W-1:0] ViewIdx;
   logic [IDX_W:0]   Count;
   logic             Empty;

   modport master (
      output En, FullIn, sw, Prev, Next, ClrOvf,
      input  Out, OvfSticky, ViewIdx, Count, Empty
   );

   modport slave (
      input  En, FullIn, sw, Prev, Next, ClrOvf,
      output Out, OvfSticky, ViewIdx, Count, Empty
   );
endinterface

// File: rtl/alu_result_hist.sv
// Registered ALU result display stage with a circular history of
// {overflow, data} entries. The operator scrolls with Prev/Next edges, the LED
// output shows the data or overflow flag of the viewed entry one cycle later,
// and a sticky overflow flag is held until explicitly cleared.
module alu_result_hist #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic            Clk,
   input  logic            Rst,
   alu_result_hist_if.slave bus
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = IDX_W + 1;

   // history storage and bookkeeping
   logic [WIDTH:0]   mem_r [DEPTH];
   logic [IDX_W-1:0] wrPtr_r;
   logic [CNT_W-1:0] count_r;
   logic [IDX_W-1:0] viewIdx_r;
   logic             ovfSticky_r;
   logic [WIDTH-1:0] out_r;
   logic             prevQ_r;
   logic             nextQ_r;

   // combinational next-state values
   logic             pe_s;
   logic             ne_s;
   logic [IDX_W-1:0] rdAddr_s;
   logic [WIDTH:0]   entry_s;
   logic [CNT_W-1:0] countNext_s;
   logic [IDX_W-1:0] viewNext_s;
   logic [WIDTH-1:0] outNext_s;
   logic             ovfNext_s;

   // LED value for one entry: data field, or the overflow flag spread over
   // every LED when the overflow view is selected
   function automatic logic [WIDTH-1:0] ledValue(input logic [WIDTH:0] entry,
                                                 input logic           ovfView);
      logic [WIDTH-1:0] led;
      if (ovfView) begin
         led = {WIDTH{entry[WIDTH]}};
      end else begin
         led = entry[WIDTH-1:0];
      end
      return led;
   endfunction

   assign pe_s     = bus.Prev & ~prevQ_r;
   assign ne_s     = bus.Next & ~nextQ_r;
   // newest entry sits just behind the write pointer; wrap is free at power-of-two depth
   assign rdAddr_s = wrPtr_r - IDX_W'(1) - viewIdx_r;
   assign entry_s  = mem_r[rdAddr_s];

   // next count, view position, LED value and sticky overflow
   always_comb begin
      countNext_s = count_r;
      viewNext_s  = viewIdx_r;
      outNext_s   = '0;
      ovfNext_s   = ovfSticky_r;

      if (bus.En && (count_r != CNT_W'(DEPTH))) begin
         countNext_s = count_r + CNT_W'(1);
      end else begin
         countNext_s = count_r;
      end

      // a capture snaps to the newest entry and swallows any scroll edge
      if (bus.En) begin
         viewNext_s = '0;
      end else if (count_r == CNT_W'(0)) begin
         viewNext_s = '0;
      end else begin
         case ({pe_s, ne_s})
            2'b10: begin
               if ({1'b0, viewIdx_r} < (count_r - CNT_W'(1))) begin
                  viewNext_s = viewIdx_r + IDX_W'(1);
               end else begin
                  viewNext_s = viewIdx_r;
               end
            end
            2'b01: begin
               if (viewIdx_r != IDX_W'(0)) begin
                  viewNext_s = viewIdx_r - IDX_W'(1);
               end else begin
                  viewNext_s = viewIdx_r;
               end
            end
            default: viewNext_s = viewIdx_r;
         endcase
      end

      if (count_r == CNT_W'(0)) begin
         outNext_s = '0;
      end else begin
         outNext_s = ledValue(entry_s, bus.sw);
      end

      // setting wins over clearing when both happen together
      if (bus.En && bus.FullIn[WIDTH]) begin
         ovfNext_s = 1'b1;
      end else if (bus.ClrOvf) begin
         ovfNext_s = 1'b0;
      end else begin
         ovfNext_s = ovfSticky_r;
      end
   end

   // history write port; reset wipes every entry
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (bus.En) begin
         mem_r[wrPtr_r] <= bus.FullIn;
      end
   end

   // control state, edge-detect history and registered LED output
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wrPtr_r     <= '0;
         count_r     <= '0;
         viewIdx_r   <= '0;
         ovfSticky_r <= 1'b0;
         out_r       <= '0;
         prevQ_r     <= 1'b0;
         nextQ_r     <= 1'b0;
      end else begin
         if (bus.En) begin
            wrPtr_r <= wrPtr_r + IDX_W'(1);
         end
         count_r     <= countNext_s;
         viewIdx_r   <= viewNext_s;
         ovfSticky_r <= ovfNext_s;
         out_r       <= outNext_s;
         prevQ_r     <= bus.Prev;
         nextQ_r     <= bus.Next;
      end
   end

   assign bus.Out       = out_r;
   assign bus.OvfSticky = ovfSticky_r;
   assign bus.ViewIdx   = viewIdx_r;
   assign bus.Count     = count_r;
   assign bus.Empty     = (count_r == CNT_W'(0));
endmodule

// File: tb/tb_alu_result_hist.sv
// Directed, table-driven bench for alu_result_hist (WIDTH=4, DEPTH=4).
// Each row is one clock cycle: inputs driven on the falling edge, registered
// outputs compared just after the following rising edge.
module tb_alu_result_hist;
   logic Clk;
   logic Rst;

   alu_result_hist_if #(.WIDTH(4), .DEPTH(4)) bus ();

   alu_result_hist #(.WIDTH(4), .DEPTH(4)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic       rst;
      logic       en;
      logic [4:0] fin;
      logic       sw;
      logic       prv;
      logic       nxt;
      logic       clr;
      logic [3:0] eOut;
      logic       eOvf;
      logic [1:0] eView;
      logic [2:0] eCnt;
      logic       eEmpty;
   } vec_t;

   int passCnt  = 0;
   int totalCnt = 0;
   vec_t tbl [42];

   function automatic vec_t mk(input logic rst, input logic en, input logic [4:0] fin,
                               input logic sw, input logic prv, input logic nxt,
                               input logic clr, input logic [3:0] eOut, input logic eOvf,
                               input logic [1:0] eView, input logic [2:0] eCnt,
                               input logic eEmpty);
      vec_t v;
      v.rst = rst; v.en = en; v.fin = fin; v.sw = sw; v.prv = prv; v.nxt = nxt;
      v.clr = clr; v.eOut = eOut; v.eOvf = eOvf; v.eView = eView; v.eCnt = eCnt;
      v.eEmpty = eEmpty;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act,
                      input logic [7:0] exp);
      totalCnt++;
      if (act === exp) begin
         passCnt++;
      end else begin
         $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic runVec(input vec_t v, input int idx);
      @(negedge Clk);
      Rst        = v.rst;
      bus.En     = v.en;
      bus.FullIn = v.fin;
      bus.sw     = v.sw;
      bus.Prev   = v.prv;
      bus.Next   = v.nxt;
      bus.ClrOvf = v.clr;
      @(posedge Clk);
      #1;
      chk("Out",       idx, {4'b0, bus.Out},     {4'b0, v.eOut});
      chk("OvfSticky", idx, {7'b0, bus.OvfSticky}, {7'b0, v.eOvf});
      chk("ViewIdx",   idx, {6'b0, bus.ViewIdx}, {6'b0, v.eView});
      chk("Count",     idx, {5'b0, bus.Count},   {5'b0, v.eCnt});
      chk("Empty",     idx, {7'b0, bus.Empty},   {7'b0, v.eEmpty});
   endtask

   initial begin
      Rst = 1'b0; bus.En = 1'b0; bus.FullIn = 5'h00; bus.sw = 1'b0;
      bus.Prev = 1'b0; bus.Next = 1'b0; bus.ClrOvf = 1'b0;

      //            rst en  fin   sw prv nxt clr  out  ovf view cnt empty
      // reset held two cycles while capturing
      tbl[0]  = mk(0, 1, 5'h07, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      tbl[1]  = mk(0, 1, 5'h07, 0, 0, 0, 0, 4'h0, 0, 0, 0, 1);
      // fill with 1..5, wrapping over the oldest
      tbl[2]  = mk(1, 1, 5'h01, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
      tbl[3]  = mk(1, 1, 5'h02, 0, 0, 0, 0, 4'h1, 0, 0, 2, 0);
      tbl[4]  = mk(1, 1, 5'h03, 0, 0, 0, 0, 4'h2, 0, 0, 3, 0);
      tbl[5]  = mk(1, 1, 5'h04, 0, 0, 0, 0, 4'h3, 0, 0, 4, 0);
      tbl[6]  = mk(1, 1, 5'h05, 0, 0, 0, 0, 4'h4, 0, 0, 4, 0);
      tbl[7]  = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h5, 0, 0, 4, 0);
      // Prev x4: 4, 3, 2, then holds at the oldest
      tbl[8]  = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h5, 0, 1, 4, 0);
      tbl[9]  = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h4, 0, 1, 4, 0);
      tbl[10] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h4, 0, 2, 4, 0);
      tbl[11] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h3, 0, 2, 4, 0);
      tbl[12] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h3, 0, 3, 4, 0);
      tbl[13] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h2, 0, 3, 4, 0);
      tbl[14] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h2, 0, 3, 4, 0);
      tbl[15] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h2, 0, 3, 4, 0);
      // Next back to age 2, then capture 0x0A together with a Prev edge
      tbl[16] = mk(1, 0, 5'h00, 0, 0, 1, 0, 4'h2, 0, 2, 4, 0);
      tbl[17] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h3, 0, 2, 4, 0);
      tbl[18] = mk(1, 1, 5'h0A, 0, 1, 0, 0, 4'h3, 0, 0, 4, 0);
      tbl[19] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'hA, 0, 0, 4, 0);
      tbl[20] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'hA, 0, 0, 4, 0);
      // overflow view
      tbl[21] = mk(1, 1, 5'h13, 1, 0, 0, 0, 4'h0, 1, 0, 4, 0);
      tbl[22] = mk(1, 0, 5'h00, 1, 0, 0, 0, 4'hF, 1, 0, 4, 0);
      tbl[23] = mk(1, 1, 5'h01, 1, 0, 0, 0, 4'hF, 1, 0, 4, 0);
      tbl[24] = mk(1, 0, 5'h00, 1, 0, 0, 0, 4'h0, 1, 0, 4, 0);
      tbl[25] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h1, 1, 0, 4, 0);
      // sticky clear: set wins, then clear alone
      tbl[26] = mk(1, 1, 5'h10, 0, 0, 0, 1, 4'h1, 1, 0, 4, 0);
      tbl[27] = mk(1, 0, 5'h00, 0, 0, 0, 1, 4'h0, 0, 0, 4, 0);
      // Prev held high five cycles moves once
      tbl[28] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h0, 0, 1, 4, 0);
      tbl[29] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h1, 0, 1, 4, 0);
      tbl[30] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h1, 0, 1, 4, 0);
      tbl[31] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h1, 0, 1, 4, 0);
      tbl[32] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h1, 0, 1, 4, 0);
      tbl[33] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h1, 0, 1, 4, 0);
      // Prev and Next together: no change
      tbl[34] = mk(1, 0, 5'h00, 0, 1, 1, 0, 4'h1, 0, 1, 4, 0);
      tbl[35] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h1, 0, 1, 4, 0);
      // Next to newest, then Next at age 0 holds
      tbl[36] = mk(1, 0, 5'h00, 0, 0, 1, 0, 4'h1, 0, 0, 4, 0);
      tbl[37] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h0, 0, 0, 4, 0);
      tbl[38] = mk(1, 0, 5'h00, 0, 0, 1, 0, 4'h0, 0, 0, 4, 0);
      tbl[39] = mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h0, 0, 0, 4, 0);
      // reset mid-scroll and mid-capture, then a Prev edge on an empty history
      tbl[40] = mk(0, 1, 5'h1F, 0, 1, 0, 0, 4'h0, 0, 0, 0, 1);
      tbl[41] = mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h0, 0, 0, 0, 1);

      for (int i = 0; i < 42; i++) begin
         runVec(tbl[i], i);
      end

      // partial fill: scrolling stops at Count-1 = 1
      runVec(mk(1, 1, 5'h03, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0), 100);
      runVec(mk(1, 1, 5'h04, 0, 0, 0, 0, 4'h3, 0, 0, 2, 0), 101);
      runVec(mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h4, 0, 1, 2, 0), 102);
      runVec(mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h3, 0, 1, 2, 0), 103);
      runVec(mk(1, 0, 5'h00, 0, 1, 0, 0, 4'h3, 0, 1, 2, 0), 104);
      runVec(mk(1, 0, 5'h00, 0, 0, 0, 0, 4'h3, 0, 1, 2, 0), 105);

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end
endmodule
